// File: rtl/weighted_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : weighted_sum_accumulator
// Description : Accumulates N_TILES accepted weighted sums per group and adds
//               a per-group bias. The group total is saturated to WIDTH bits
//               and held on a ready/valid output until downstream accepts it.
// Revision    : 1.0 - initial release
// ============================================================================
module weighted_sum_accumulator #(
    parameter int WIDTH     = 16,
    parameter int N_TILES   = 4,
    parameter int ACC_WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_sum,
    input  logic [WIDTH-1:0] bias,
    input  logic             clear,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_sat,
    output logic [7:0]       tile_idx
);

    localparam int                   c_ACC_MIN  = WIDTH + $clog2(N_TILES + 1);
    localparam logic [7:0]           c_LAST_IDX = 8'(N_TILES - 1);
    localparam logic [ACC_WIDTH-1:0] c_RES_MAX  = {{(ACC_WIDTH-WIDTH){1'b0}}, {WIDTH{1'b1}}};

    // Reject parameter sets that could overflow the accumulator or the index.
    generate
        if ((ACC_WIDTH < c_ACC_MIN) || (N_TILES < 1) || (N_TILES > 255)) begin : g_param_check
            $error("weighted_sum_accumulator: illegal N_TILES/ACC_WIDTH combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [ACC_WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]       r_bias;
    logic [7:0]             r_tile_idx;
    logic [WIDTH-1:0]       r_result;
    logic                   r_sat;

    logic                   w_load_first;
    logic                   w_add;
    logic                   w_enter_done;
    logic                   w_release;
    logic                   w_clear_grp;
    logic [ACC_WIDTH-1:0]   w_sum_ext;
    logic [ACC_WIDTH-1:0]   w_acc_next;
    logic [WIDTH-1:0]       w_bias_eff;
    logic [ACC_WIDTH-1:0]   w_total;
    logic                   w_over;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state decode and per-cycle datapath controls; clear beats a beat.
    always_comb begin
        w_state_next = r_state;
        w_load_first = 1'b0;
        w_add        = 1'b0;
        w_enter_done = 1'b0;
        w_release    = 1'b0;
        w_clear_grp  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (clear) begin
                    w_clear_grp = 1'b1;
                end else if (in_valid) begin
                    w_load_first = 1'b1;
                    if (N_TILES == 1) begin
                        w_enter_done = 1'b1;
                        w_state_next = S_DONE;
                    end else begin
                        w_state_next = S_ACCUM;
                    end
                end
            end
            S_ACCUM: begin
                if (clear) begin
                    w_clear_grp  = 1'b1;
                    w_state_next = S_IDLE;
                end else if (in_valid) begin
                    w_add = 1'b1;
                    if (r_tile_idx == c_LAST_IDX) begin
                        w_enter_done = 1'b1;
                        w_state_next = S_DONE;
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_release    = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Accumulator input and the group total that is formed on the last beat.
    always_comb begin
        w_sum_ext  = {{(ACC_WIDTH-WIDTH){1'b0}}, in_sum};
        w_acc_next = w_load_first ? w_sum_ext : (r_acc + w_sum_ext);
        w_bias_eff = w_load_first ? bias : r_bias;
        w_total    = w_acc_next + {{(ACC_WIDTH-WIDTH){1'b0}}, w_bias_eff};
        w_over     = (w_total > c_RES_MAX);
    end

    // Accumulator, bias capture, beat index and registered saturated result.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_bias     <= '0;
            r_tile_idx <= '0;
            r_result   <= '0;
            r_sat      <= 1'b0;
        end else begin
            if (w_clear_grp || w_release) begin
                r_acc      <= '0;
                r_tile_idx <= '0;
            end else if (w_load_first || w_add) begin
                r_acc      <= w_acc_next;
                // The index counts beats of a group still in progress, so it
                // wraps to zero once the group is complete.
                r_tile_idx <= w_enter_done ? 8'd0 : (r_tile_idx + 8'd1);
            end

            if (w_load_first) begin
                r_bias <= bias;
            end

            if (w_enter_done) begin
                r_result <= w_over ? {WIDTH{1'b1}} : w_total[WIDTH-1:0];
                r_sat    <= w_over;
            end else if (w_release) begin
                r_result <= '0;
                r_sat    <= 1'b0;
            end
        end
    end

    assign in_ready   = (r_state != S_DONE);
    assign out_valid  = (r_state == S_DONE);
    assign out_result = r_result;
    assign out_sat    = r_sat;
    assign tile_idx   = r_tile_idx;

endmodule
`default_nettype wire

// File: tb/tb_weighted_sum_accumulator.sv
`default_nettype none
// ============================================================================
// Module      : tb_weighted_sum_accumulator
// Description : Directed bench for weighted_sum_accumulator, one 4-tile
//               instance and one single-tile instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_weighted_sum_accumulator;

    logic        clk = 1'b0;
    logic        rst;

    // 4-tile instance
    logic        in_valid, in_ready, clear, out_valid, out_ready, out_sat;
    logic [15:0] in_sum, bias, out_result;
    logic [7:0]  tile_idx;

    // single-tile instance
    logic        b_in_valid, b_in_ready, b_clear, b_out_valid, b_out_ready, b_out_sat;
    logic [15:0] b_in_sum, b_bias, b_out_result;
    logic [7:0]  b_tile_idx;

    int n_cmp  = 0;
    int n_fail = 0;

    weighted_sum_accumulator #(.WIDTH(16), .N_TILES(4), .ACC_WIDTH(20)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sum(in_sum), .bias(bias),
        .clear(clear), .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_sat(out_sat), .tile_idx(tile_idx)
    );

    weighted_sum_accumulator #(.WIDTH(16), .N_TILES(1), .ACC_WIDTH(17)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_sum(b_in_sum), .bias(b_bias),
        .clear(b_clear), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .out_result(b_out_result), .out_sat(b_out_sat), .tile_idx(b_tile_idx)
    );

    always #5 clk = ~clk;

    // One comparison: counts it and reports any difference.
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [15:0] v);
        in_valid = 1'b1;
        in_sum   = v;
        step();
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 0; in_sum = 0; bias = 0; clear = 0; out_ready = 0;
        b_in_valid = 0; b_in_sum = 0; b_bias = 0; b_clear = 0; b_out_ready = 0;
        step();
        step();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_tile_idx", tile_idx, 0);
        rst = 1'b0;
        step();
        chk("post_rst_in_ready", in_ready, 1);

        // Basic group: 48+40+23+37+2 = 150
        bias = 16'd2; out_ready = 1'b1;
        beat(16'd48);
        chk("g1_tile1", tile_idx, 1);
        beat(16'd40);
        chk("g1_tile2", tile_idx, 2);
        beat(16'd23);
        chk("g1_not_valid_yet", out_valid, 0);
        beat(16'd37);
        chk("g1_out_valid", out_valid, 1);
        chk("g1_out_result", out_result, 150);
        chk("g1_out_sat", out_sat, 0);
        chk("g1_in_ready_done", in_ready, 0);
        in_valid = 1'b0;
        step();
        chk("g1_idle_valid", out_valid, 0);
        chk("g1_idle_result", out_result, 0);
        chk("g1_idle_tile", tile_idx, 0);
        chk("g1_idle_ready", in_ready, 1);

        // Saturation: 4*0xFFFF + 1 clamps to 0xFFFF
        bias = 16'd1;
        beat(16'hFFFF); beat(16'hFFFF); beat(16'hFFFF); beat(16'hFFFF);
        chk("sat_result", out_result, 16'hFFFF);
        chk("sat_flag", out_sat, 1);
        in_valid = 1'b0;
        step();
        chk("sat_released", out_valid, 0);
        chk("sat_flag_cleared", out_sat, 0);

        // Backpressure: 100 held for 3 cycles, offered beats ignored
        bias = 16'd0; out_ready = 1'b0;
        beat(16'd10); beat(16'd20); beat(16'd30); beat(16'd40);
        chk("bp_result", out_result, 100);
        in_valid = 1'b1; in_sum = 16'd99;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_result", out_result, 100);
            chk("bp_in_ready", in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        chk("bp_released", out_valid, 0);
        chk("bp_no_beat_on_release", tile_idx, 0);
        in_valid = 1'b0;
        step();
        chk("bp_still_idle", tile_idx, 0);

        // Clear wins over a simultaneous beat
        beat(16'd5); beat(16'd6);
        chk("clr_tile2", tile_idx, 2);
        clear = 1'b1;
        beat(16'd7);
        clear = 1'b0;
        chk("clr_tile0", tile_idx, 0);
        chk("clr_not_valid", out_valid, 0);
        beat(16'd1); beat(16'd1); beat(16'd1); beat(16'd1);
        chk("clr_result", out_result, 4);
        chk("clr_valid", out_valid, 1);
        in_valid = 1'b0;
        step();

        // Reset mid-group, then a group with a gap
        beat(16'd8); beat(16'd8);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_tile", tile_idx, 0);
        chk("midrst_ready", in_ready, 1);
        beat(16'd3);
        in_valid = 1'b0;
        step();
        chk("gap_tile_hold", tile_idx, 1);
        beat(16'd3); beat(16'd3); beat(16'd3);
        chk("midrst_result", out_result, 12);
        in_valid = 1'b0;
        step();
        chk("midrst_tile_after", tile_idx, 0);

        // Clear ignored in DONE: 1+2+3+4+7 = 17
        bias = 16'd7; out_ready = 1'b0;
        beat(16'd1); beat(16'd2); beat(16'd3); beat(16'd4);
        in_valid = 1'b0; clear = 1'b1;
        step(); step();
        chk("done_clear_valid", out_valid, 1);
        chk("done_clear_result", out_result, 17);
        clear = 1'b0;

        // Reset in DONE drops the pending result
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("done_rst_valid", out_valid, 0);
        chk("done_rst_result", out_result, 0);

        // Single-tile instance: 9+5 = 14, then one result every 2 cycles
        b_bias = 16'd5; b_out_ready = 1'b1;
        b_in_valid = 1'b1; b_in_sum = 16'd9;
        step();
        chk("n1_valid", b_out_valid, 1);
        chk("n1_result", b_out_result, 14);
        chk("n1_in_ready", b_in_ready, 0);
        b_in_sum = 16'd20;
        step();
        chk("n1_release", b_out_valid, 0);
        step();
        chk("n1_valid2", b_out_valid, 1);
        chk("n1_result2", b_out_result, 25);
        b_in_valid = 1'b0;
        step();
        chk("n1_idle", b_out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/weighted_sum_accumulator.md
WEIGHTED_SUM_ACCUMULATOR -- requirements
Module: weighted_sum_accumulator

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning the width of incoming weighted sums and of the result.
REQ-002 SHALL have parameter N_TILES, default 4, meaning the number of accepted sums per output group; legal range 1..255.
REQ-003 SHALL have parameter ACC_WIDTH, default 20, meaning the internal accumulator width; it SHALL be at least WIDTH+clog2(N_TILES+1).
REQ-004 SHALL have port clk  input  1  system clock; one clock domain, all state on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  in_sum is valid this cycle.
REQ-007 SHALL have port in_ready  output  1  block can accept in_sum this cycle.
REQ-008 SHALL have port in_sum  input  WIDTH  unsigned weighted sum from the upstream pipelined summation stage.
REQ-009 SHALL have port bias  input  WIDTH  unsigned bias, sampled on the first accepted beat of each group.
REQ-010 SHALL have port clear  input  1  abort the current partial group.
REQ-011 SHALL have port out_valid  output  1  out_result is valid.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_result.
REQ-013 SHALL have port out_result  output  WIDTH  saturated group total (sum of beats plus bias).
REQ-014 SHALL have port out_sat  output  1  out_result was clamped.
REQ-015 SHALL have port tile_idx  output  8  number of beats accepted in the current group (0..N_TILES-1).

Function
REQ-016 SHALL implement an FSM with states IDLE, ACCUM and DONE.
REQ-017 SHALL treat a beat as accepted when in_valid and in_ready are both 1 on a rising edge.
REQ-018 SHALL drive in_ready=1 in IDLE and ACCUM, and in_ready=0 in DONE (combinational from state only).
REQ-019 SHALL, on an accepted beat in IDLE, load acc=in_sum, capture bias, set tile_idx=1, and enter ACCUM; if N_TILES=1, it SHALL enter DONE instead.
REQ-020 SHALL, on an accepted beat in ACCUM, compute acc=acc+in_sum (zero-extended to ACC_WIDTH) and increment tile_idx.
REQ-021 SHALL enter DONE on the edge that accepts the N_TILES-th beat, with out_valid=1 on the next cycle (one-cycle latency from the last beat).
REQ-022 SHALL compute total=acc_final+bias_captured in ACC_WIDTH and register out_result=min(total, 2^WIDTH-1) on DONE entry; out_sat SHALL be 1 iff total>2^WIDTH-1.
REQ-023 SHALL hold out_valid, out_result and out_sat stable in DONE until out_ready=1.
REQ-024 SHALL, on out_valid and out_ready both 1, return to IDLE next cycle with out_valid=0, tile_idx=0 and acc=0; no beat is accepted in that cycle.
REQ-025 SHALL hold state, acc and tile_idx when in_valid=0 in IDLE or ACCUM (gaps are allowed).
REQ-026 SHALL, on clear=1 in IDLE or ACCUM, return to IDLE with acc=0 and tile_idx=0; clear SHALL take precedence over a simultaneous beat, and that beat SHALL be dropped.
REQ-027 SHALL ignore clear in DONE; a pending result SHALL never be discarded except by rst.
REQ-028 SHALL never overflow acc; the width rule in REQ-003 guarantees this.
REQ-029 SHALL drive out_result and out_sat as 0 whenever out_valid=0.

Reset
REQ-030 SHALL, while rst=1 at a rising edge, force IDLE, acc=0, bias_captured=0, tile_idx=0, out_valid=0, out_result=0 and out_sat=0.
REQ-031 SHALL give rst priority over every other input, including mid-group and in DONE; the pending result SHALL be lost.
REQ-032 SHALL drive in_ready=1 in the first cycle after rst deasserts.

Verification
REQ-033 SHALL pass this case: bias=2, beats 48,40,23,37 on consecutive cycles, out_ready=1 -> one cycle after the 4th beat, out_valid=1, out_result=150, out_sat=0; IDLE on the next cycle.
REQ-034 SHALL pass this case: bias=1, four beats of 0xFFFF -> out_result=0xFFFF, out_sat=1.
REQ-035 SHALL pass this case: group 10,20,30,40 with bias=0 and out_ready held 0 for 3 cycles -> out_result=100 held stable and in_ready=0 throughout; a beat offered during this window SHALL NOT be counted.
REQ-036 SHALL pass this case: beats 5,6 then clear together with a beat of 7, then 1,1,1,1 with bias=0 -> out_result=4.
REQ-037 SHALL pass this case: rst asserted after 2 beats, then a fresh group 3,3,3,3 with bias=0 -> out_result=12, tile_idx=0 after the handshake.
REQ-038 SHALL pass this case: N_TILES=1, bias=5, beat 9 -> out_result=14 one cycle later; back-to-back groups with out_ready=1 produce one result every 2 cycles.
